// File: rtl/chiffon_axi_pkg.sv
// Shared AXI encodings and the write-channel state type for the membus bridge.
package chiffon_axi_pkg;

   localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;
   localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
   localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;

   typedef enum logic [1:0] {IDLE, ADDR_DATA, WAIT_B} wstate_t;

endpackage

// File: rtl/membus_axi_bridge_fifo.sv
// Small synchronous FIFO holding the lane index of each outstanding read.
module sync_fifo #(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wdata;
   end

   assign rdata = mem[rd_ptr];

endmodule

// File: rtl/membus_axi_bridge.sv
// Core membus to AXI4 master bridge: in-order pipelined reads, single-beat writes,
// dram_base offset, byte-lane steering and a sticky bus-error flag.
module membus_axi_bridge
   import chiffon_axi_pkg::*;
#(
   parameter int unsigned AXI_ID_W        = 1,
   parameter int unsigned AXI_ADDR_W      = 32,
   parameter int unsigned AXI_DATA_W      = 32,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                    ACLK,
   input  logic                    ARST,
   input  logic [31:0]             dram_base,
   input  logic                    mem_valid,
   output logic                    mem_ready,
   input  logic [31:0]             mem_addr,
   input  logic                    mem_wen,
   input  logic [31:0]             mem_wdata,
   input  logic [3:0]              mem_wmask,
   output logic                    mem_rvalid,
   output logic [31:0]             mem_rdata,
   output logic [AXI_ID_W-1:0]     M_AXI_AWID,
   output logic [AXI_ADDR_W-1:0]   M_AXI_AWADDR,
   output logic [7:0]              M_AXI_AWLEN,
   output logic [2:0]              M_AXI_AWSIZE,
   output logic [1:0]              M_AXI_AWBURST,
   output logic                    M_AXI_AWLOCK,
   output logic [3:0]              M_AXI_AWCACHE,
   output logic [2:0]              M_AXI_AWPROT,
   output logic [3:0]              M_AXI_AWQOS,
   output logic                    M_AXI_AWVALID,
   input  logic                    M_AXI_AWREADY,
   output logic [AXI_DATA_W-1:0]   M_AXI_WDATA,
   output logic [AXI_DATA_W/8-1:0] M_AXI_WSTRB,
   output logic                    M_AXI_WLAST,
   output logic                    M_AXI_WVALID,
   input  logic                    M_AXI_WREADY,
   input  logic [AXI_ID_W-1:0]     M_AXI_BID,
   input  logic [1:0]              M_AXI_BRESP,
   input  logic                    M_AXI_BVALID,
   output logic                    M_AXI_BREADY,
   output logic [AXI_ID_W-1:0]     M_AXI_ARID,
   output logic [AXI_ADDR_W-1:0]   M_AXI_ARADDR,
   output logic [7:0]              M_AXI_ARLEN,
   output logic [2:0]              M_AXI_ARSIZE,
   output logic [1:0]              M_AXI_ARBURST,
   output logic                    M_AXI_ARLOCK,
   output logic [3:0]              M_AXI_ARCACHE,
   output logic [2:0]              M_AXI_ARPROT,
   output logic [3:0]              M_AXI_ARQOS,
   output logic                    M_AXI_ARVALID,
   input  logic                    M_AXI_ARREADY,
   input  logic [AXI_ID_W-1:0]     M_AXI_RID,
   input  logic [AXI_DATA_W-1:0]   M_AXI_RDATA,
   input  logic [1:0]              M_AXI_RRESP,
   input  logic                    M_AXI_RLAST,
   input  logic                    M_AXI_RVALID,
   output logic                    M_AXI_RREADY,
   output logic                    err,
   output logic [31:0]             last_addr
);

   localparam int unsigned STRB_W = AXI_DATA_W / 8;
   localparam int unsigned SIZE   = $clog2(STRB_W);
   localparam int unsigned LANES  = AXI_DATA_W / 32;
   localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING + 1);

   wstate_t             wstate;
   logic [CNT_W-1:0]    rd_cnt;
   logic [31:0]         sum_addr, aligned_addr;
   logic [AXI_ADDR_W-1:0] axi_addr;
   logic [LANE_W-1:0]   req_lane, rsp_lane;
   logic                acc, rd_acc, wr_acc, r_hs, aw_done, w_done;
   logic                unused_inputs;

   assign sum_addr     = dram_base + mem_addr;
   assign aligned_addr = sum_addr & ~32'(STRB_W - 1);
   assign axi_addr     = AXI_ADDR_W'(aligned_addr);

   if (LANES > 1) begin : g_lane
      assign req_lane = sum_addr[SIZE-1:2];
   end else begin : g_no_lane
      assign req_lane = '0;
   end

   // Writes only start from an empty read pipe, so read and write completions never collide.
   assign mem_ready = ~M_AXI_ARVALID & (wstate == IDLE) & (rd_cnt < CNT_W'(MAX_OUTSTANDING))
                      & (~mem_wen | (rd_cnt == '0));
   assign acc    = mem_valid & mem_ready;
   assign rd_acc = acc & ~mem_wen;
   assign wr_acc = acc & mem_wen;

   assign M_AXI_RREADY = (rd_cnt != '0);
   assign r_hs         = M_AXI_RVALID & M_AXI_RREADY;
   assign aw_done      = ~M_AXI_AWVALID | M_AXI_AWREADY;
   assign w_done       = ~M_AXI_WVALID | M_AXI_WREADY;

   assign M_AXI_AWID    = '0;
   assign M_AXI_AWLEN   = 8'd0;
   assign M_AXI_AWSIZE  = 3'(SIZE);
   assign M_AXI_AWBURST = AXI_BURST_INCR;
   assign M_AXI_AWLOCK  = 1'b0;
   assign M_AXI_AWCACHE = AXI_CACHE_DEFAULT;
   assign M_AXI_AWPROT  = 3'd0;
   assign M_AXI_AWQOS   = 4'd0;
   assign M_AXI_WLAST   = 1'b1;
   assign M_AXI_ARID    = '0;
   assign M_AXI_ARLEN   = 8'd0;
   assign M_AXI_ARSIZE  = 3'(SIZE);
   assign M_AXI_ARBURST = AXI_BURST_INCR;
   assign M_AXI_ARLOCK  = 1'b0;
   assign M_AXI_ARCACHE = AXI_CACHE_DEFAULT;
   assign M_AXI_ARPROT  = 3'd0;
   assign M_AXI_ARQOS   = 4'd0;

   assign unused_inputs = ^{M_AXI_BID, M_AXI_RID, M_AXI_RLAST};

   sync_fifo #(
      .WIDTH (LANE_W),
      .DEPTH (MAX_OUTSTANDING)
   ) u_lane_fifo (
      .clk   (ACLK),
      .rst   (ARST),
      .push  (rd_acc),
      .wdata (req_lane),
      .pop   (r_hs),
      .rdata (rsp_lane)
   );

   always_ff @(posedge ACLK or posedge ARST) begin
      if (ARST) begin
         M_AXI_ARVALID <= 1'b0;
         M_AXI_ARADDR  <= '0;
         M_AXI_AWVALID <= 1'b0;
         M_AXI_AWADDR  <= '0;
         M_AXI_WVALID  <= 1'b0;
         M_AXI_WDATA   <= '0;
         M_AXI_WSTRB   <= '0;
         M_AXI_BREADY  <= 1'b0;
         wstate        <= IDLE;
         rd_cnt        <= '0;
         mem_rvalid    <= 1'b0;
         mem_rdata     <= '0;
         err           <= 1'b0;
         last_addr     <= '0;
      end else begin
         mem_rvalid <= 1'b0;
         if (acc) last_addr <= aligned_addr;

         if (rd_acc) begin
            M_AXI_ARVALID <= 1'b1;
            M_AXI_ARADDR  <= axi_addr;
         end else if (M_AXI_ARREADY) begin
            M_AXI_ARVALID <= 1'b0;
         end

         case ({rd_acc, r_hs})
            2'b10:   rd_cnt <= rd_cnt + 1'b1;
            2'b01:   rd_cnt <= rd_cnt - 1'b1;
            default: rd_cnt <= rd_cnt;
         endcase

         if (r_hs) begin
            mem_rvalid <= 1'b1;
            mem_rdata  <= M_AXI_RDATA[32'(rsp_lane) * 32 +: 32];
            if (M_AXI_RRESP != AXI_RESP_OKAY) err <= 1'b1;
         end

         case (wstate)
            IDLE: begin
               if (wr_acc) begin
                  M_AXI_AWVALID <= 1'b1;
                  M_AXI_WVALID  <= 1'b1;
                  M_AXI_AWADDR  <= axi_addr;
                  M_AXI_WDATA   <= {LANES{mem_wdata}};
                  M_AXI_WSTRB   <= STRB_W'(mem_wmask) << (32'(req_lane) * 4);
                  wstate        <= ADDR_DATA;
               end
            end
            ADDR_DATA: begin
               if (M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
               if (M_AXI_WREADY)  M_AXI_WVALID  <= 1'b0;
               if (aw_done && w_done) begin
                  M_AXI_BREADY <= 1'b1;
                  wstate       <= WAIT_B;
               end
            end
            WAIT_B: begin
               if (M_AXI_BVALID) begin
                  M_AXI_BREADY <= 1'b0;
                  mem_rvalid   <= 1'b1;
                  mem_rdata    <= '0;
                  wstate       <= IDLE;
                  if (M_AXI_BRESP != AXI_RESP_OKAY) err <= 1'b1;
               end
            end
            default: wstate <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_membus_axi_bridge.sv
// Directed bench for membus_axi_bridge (128-bit AXI data) with a response scoreboard.
module tb_membus_axi_bridge;

   localparam logic [31:0] BASE = 32'h1000_0000;

   logic         ACLK, ARST;
   logic [31:0]  dram_base, mem_addr, mem_wdata, mem_rdata, last_addr;
   logic         mem_valid, mem_ready, mem_wen, mem_rvalid, err;
   logic [3:0]   mem_wmask;
   logic [0:0]   awid, bid, arid, rid;
   logic [31:0]  awaddr, araddr;
   logic [7:0]   awlen, arlen;
   logic [2:0]   awsize, arsize, awprot, arprot;
   logic [1:0]   awburst, arburst, bresp, rresp;
   logic         awlock, arlock;
   logic [3:0]   awcache, arcache, awqos, arqos;
   logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic         arvalid, arready, rlast, rvalid, rready;
   logic [127:0] wdata, rdata;
   logic [15:0]  wstrb;

   int n_tests = 0, n_fail = 0, pulses = 0, ar_cnt = 0;
   logic [31:0] exp_q[$];

   membus_axi_bridge #(
      .AXI_ID_W(1), .AXI_ADDR_W(32), .AXI_DATA_W(128), .MAX_OUTSTANDING(4)
   ) dut (
      .ACLK(ACLK), .ARST(ARST), .dram_base(dram_base),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wen(mem_wen),
      .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata),
      .M_AXI_AWID(awid), .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
      .M_AXI_AWBURST(awburst), .M_AXI_AWLOCK(awlock), .M_AXI_AWCACHE(awcache),
      .M_AXI_AWPROT(awprot), .M_AXI_AWQOS(awqos), .M_AXI_AWVALID(awvalid),
      .M_AXI_AWREADY(awready), .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast),
      .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready), .M_AXI_BID(bid), .M_AXI_BRESP(bresp),
      .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
      .M_AXI_ARID(arid), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
      .M_AXI_ARBURST(arburst), .M_AXI_ARLOCK(arlock), .M_AXI_ARCACHE(arcache),
      .M_AXI_ARPROT(arprot), .M_AXI_ARQOS(arqos), .M_AXI_ARVALID(arvalid),
      .M_AXI_ARREADY(arready), .M_AXI_RID(rid), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp),
      .M_AXI_RLAST(rlast), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
      .err(err), .last_addr(last_addr)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic [31:0] lane_word(input logic [127:0] d, input logic [31:0] addr);
      logic [31:0] a;
      a = BASE + addr;
      return d[a[3:2]*32 +: 32];
   endfunction

   // One clock; afterwards (edge + 1) any mem_rvalid pulse is scored against the queue.
   task automatic tick();
      logic ar_hs;
      logic [31:0] e;
      ar_hs = arvalid && arready;
      @(posedge ACLK);
      if (ar_hs) ar_cnt++;
      #1;
      if (mem_rvalid) begin
         pulses++;
         if (exp_q.size() == 0) check("unexpected_rvalid", 1'b1, 1'b0);
         else begin
            e = exp_q.pop_front();
            check("rdata", mem_rdata, e);
         end
      end
   endtask

   task automatic mem_req(input logic [31:0] addr, input logic wen, input logic [31:0] wd,
                          input logic [3:0] wm, input logic [31:0] expv);
      logic acc;
      acc = 1'b0;
      mem_valid = 1'b1; mem_addr = addr; mem_wen = wen; mem_wdata = wd; mem_wmask = wm;
      for (int i = 0; i < 50 && !acc; i++) begin
         #1;
         if (mem_ready) acc = 1'b1;
         tick();
      end
      mem_valid = 1'b0;
      check("req_accept", acc, 1'b1);
      if (acc) exp_q.push_back(expv);
   endtask

   task automatic r_beat(input logic [127:0] d, input logic [1:0] resp);
      logic hs;
      hs = 1'b0;
      rvalid = 1'b1; rdata = d; rresp = resp;
      for (int i = 0; i < 50 && !hs; i++) begin
         #1;
         if (rready) hs = 1'b1;
         tick();
      end
      rvalid = 1'b0;
      check("r_handshake", hs, 1'b1);
      check("rvalid_latency", mem_rvalid, 1'b1);
   endtask

   logic [127:0] d1, d5;
   logic [127:0] rd2 [4];
   int p0, a0;

   initial begin
      ARST = 1'b1; dram_base = BASE;
      mem_valid = 0; mem_addr = 0; mem_wen = 0; mem_wdata = 0; mem_wmask = 0;
      awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 0;
      arready = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 1; rid = 0;
      repeat (3) @(posedge ACLK);
      #1 ARST = 1'b0;
      tick();
      check("rst_arvalid", arvalid, 1'b0);
      check("rst_awwvalid", {awvalid, wvalid}, 2'b00);
      check("rst_rvalid", mem_rvalid, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_last_addr", last_addr, 32'h0);
      check("rst_ready_flags", {rready, bready}, 2'b00);

      // 1: single read, lane 1 of a 128-bit beat
      d1 = 128'h1111_1111_2222_2222_AAAA_BBBB_CCCC_DDDD;
      mem_req(32'h4, 1'b0, 32'h0, 4'h0, lane_word(d1, 32'h4));
      check("t1_arvalid", arvalid, 1'b1);
      check("t1_araddr", araddr, 32'h1000_0000);
      check("t1_ar_consts", {arlen, arsize, arburst, arcache}, {8'd0, 3'd4, 2'b01, 4'b0011});
      check("t1_last_addr", last_addr, 32'h1000_0000);
      tick();
      check("t1_ar_hold", {arvalid, araddr}, {1'b1, 32'h1000_0000});
      arready = 1'b1;
      tick();
      check("t1_ar_drop", arvalid, 1'b0);
      repeat (3) tick();
      r_beat(d1, 2'b00);
      repeat (2) tick();
      check("t1_pulses", pulses, 1);

      // 2: four back-to-back reads, R stalled
      a0 = ar_cnt; p0 = pulses;
      for (int i = 0; i < 4; i++) begin
         rd2[i] = {32'(i) + 32'hD000_0000, 32'(i) + 32'hC000_0000,
                   32'(i) + 32'hB000_0000, 32'(i) + 32'hA000_0000};
         mem_req(32'(i * 4), 1'b0, 32'h0, 4'h0, lane_word(rd2[i], 32'(i * 4)));
      end
      repeat (2) tick();
      check("t2_ar_count", ar_cnt - a0, 4);
      mem_wen = 1'b0;
      #1 check("t2_ready_full", mem_ready, 1'b0);
      repeat (10) tick();
      check("t2_stall_no_pulse", pulses - p0, 0);
      check("t2_ready_stalled", mem_ready, 1'b0);
      for (int i = 0; i < 4; i++) r_beat(rd2[i], 2'b00);
      tick();
      check("t2_pulses", pulses - p0, 4);

      // 3: write at lane 2, AWREADY two cycles ahead of WREADY
      mem_req(32'h8, 1'b1, 32'h1234_5678, 4'b0011, 32'h0);
      check("t3_aw_w_valid", {awvalid, wvalid}, 2'b11);
      check("t3_awaddr", awaddr, 32'h1000_0000);
      check("t3_wstrb", wstrb, 16'h0300);
      check("t3_wdata", wdata, {4{32'h1234_5678}});
      check("t3_wlast_bready", {wlast, bready}, 2'b10);
      awready = 1'b1;
      tick();
      awready = 1'b0;
      check("t3_aw_only_drop", {awvalid, wvalid}, 2'b01);
      tick();
      wready = 1'b1;
      tick();
      wready = 1'b0;
      check("t3_w_drop_bready", {wvalid, bready}, 2'b01);
      mem_wen = 1'b0;
      #1 check("t3_read_stalled", mem_ready, 1'b0);
      bvalid = 1'b1;
      tick();
      bvalid = 1'b0;
      check("t3_b_pulse", mem_rvalid, 1'b1);
      tick();
      check("t3_bready_off", bready, 1'b0);

      // 4: write held off by two outstanding reads
      mem_req(32'h0, 1'b0, 32'h0, 4'h0, lane_word(rd2[0], 32'h0));
      mem_req(32'h4, 1'b0, 32'h0, 4'h0, lane_word(rd2[1], 32'h4));
      mem_wen = 1'b1;
      #1 check("t4_blocked_2", mem_ready, 1'b0);
      r_beat(rd2[0], 2'b00);
      check("t4_blocked_1", mem_ready, 1'b0);
      r_beat(rd2[1], 2'b00);
      check("t4_unblocked", mem_ready, 1'b1);
      awready = 1'b1; wready = 1'b1;
      mem_req(32'hC, 1'b1, 32'hCAFE_F00D, 4'b1111, 32'h0);
      check("t4_wstrb", wstrb, 16'hF000);
      tick();
      awready = 1'b0; wready = 1'b0;
      check("t4_both_drop", {awvalid, wvalid, bready}, 3'b001);
      bvalid = 1'b1;
      tick();
      bvalid = 1'b0;
      check("t4_queue_empty", exp_q.size(), 0);

      // 5: error response still delivers data; err is sticky
      d5 = 128'h5555_0003_5555_0002_5555_0001_5555_0000;
      mem_req(32'h8, 1'b0, 32'h0, 4'h0, lane_word(d5, 32'h8));
      r_beat(d5, 2'b10);
      check("t5_err_set", err, 1'b1);
      mem_req(32'hC, 1'b0, 32'h0, 4'h0, lane_word(d5, 32'hC));
      r_beat(d5, 2'b00);
      tick();
      check("t5_err_sticky", err, 1'b1);

      // 6: asynchronous reset with a write address pending
      mem_req(32'h10, 1'b1, 32'h0BAD_0BAD, 4'b0001, 32'h0);
      check("t6_aw_pending", awvalid, 1'b1);
      #2 ARST = 1'b1;
      #1;
      check("t6_valids_drop", {awvalid, wvalid, arvalid, mem_rvalid, bready}, 5'b0);
      check("t6_err_clear", err, 1'b0);
      exp_q.delete();
      @(posedge ACLK);
      #1 ARST = 1'b0;
      mem_req(32'h10, 1'b0, 32'h0, 4'h0, lane_word(d5, 32'h10));
      check("t6_araddr", araddr, 32'h1000_0010);
      r_beat(d5, 2'b00);
      repeat (2) tick();
      check("t6_final_queue", exp_q.size(), 0);
      check("t6_err_after", err, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
